fifo_burst_reader: RTL and testbench

Consumer-side engine for the 8-bit inter-processor FIFO. On a start command it drains a programmed number of bytes, driving the FIFO read enable and absorbing the FIFO's 1-cycle read latency. It presents the bytes to processor 2 over a valid/ready stream, with full throughput and no data loss under backpressure. It sits between the FIFO read port and the downstream consumer.

---
 rtl/fifo_burst_reader_pkg.sv | 13 +
 rtl/fifo_skid_buf.sv | 44 ++++
 rtl/fifo_burst_reader.sv | 107 ++++++++++
 tb/tb_fifo_burst_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants for the FIFO burst reader: default widths, skid depth and FSM encodings.
package fifo_burst_reader_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LEN_W     = 5;
  localparam int DEF_BUF_DEPTH = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO that absorbs in-flight FIFO reads while the consumer stalls.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        occ_o
);

  logic [1:0][DATA_W-1:0] mem_q;
  logic                   rd_ptr_q;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_idx;

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  assign wr_idx = rd_ptr_q ^ occ_q[0];
  assign occ_d  = occ_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_idx] <= din_i;
      if (pop_i)  rd_ptr_q      <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of bytes from the inter-processor FIFO onto a valid/ready stream.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_underflow,
  output logic              fifo_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err_underflow
);

  localparam int CW = LEN_W + 1;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0]    issued_q, issued_d, delivered_q, delivered_d, len_x;
  logic             inflight_q, inflight_d, err_q, err_d;
  logic [1:0]       occ;
  logic             rd_en, pop, push, abort, credit_ok;

  assign len_x     = {1'b0, len_q};
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign busy      = (state_q == ST_RUN) | (state_q == ST_FLUSH);
  assign done      = (state_q == ST_FIN);
  assign abort     = busy & fifo_underflow;
  assign push      = inflight_q & ~abort;

  // A byte leaving this cycle frees its slot, which keeps reads going at 1 byte/cycle.
  assign credit_ok = ({1'b0, occ} + {2'b0, inflight_q}) < (3'(BUF_DEPTH) + {2'b0, pop});
  assign rd_en     = (state_q == ST_RUN) & ~fifo_empty & (issued_q < len_x) & credit_ok;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    err_d       = err_q;
    issued_d    = issued_q + CW'(rd_en);
    delivered_d = delivered_q + CW'(pop);
    inflight_d  = rd_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = burst_len;
          issued_d    = '0;
          delivered_d = '0;
          err_d       = 1'b0;
          state_d     = (burst_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN:   if (issued_d == len_x) state_d = ST_FLUSH;
      ST_FLUSH: if (delivered_d == len_x) state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
    // Underflow drops everything buffered or in flight and closes the burst.
    if (abort) begin
      err_d      = 1'b1;
      inflight_d = 1'b0;
      state_d    = ST_FIN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (abort),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_rd_data),
    .head_o  (out_data),
    .occ_o   (occ)
  );

  assign fifo_rd_en    = rd_en;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench: a queue-based FIFO model feeds the reader, a scoreboard checks order and counts.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset, start, fifo_empty, fifo_underflow, out_ready;
  logic          fifo_rd_en, out_valid, busy, done, err_underflow;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] fifo_rd_data, out_data;

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_len      (burst_len),
    .fifo_empty     (fifo_empty),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done),
    .err_underflow  (err_underflow)
  );

  int            n_checks = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] exp_q[$];  // bytes read from the FIFO, owed to the consumer in order
  int            wr_at[$];
  logic [DW-1:0] wr_b[$];
  int            rd_cycles[$];
  int            reads, deliv, done_cnt, rdy_mode;
  int            start_cyc, first_xfer, last_xfer, done_cyc;
  logic          hold_v, uf_prev;
  logic [DW-1:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(base < 0 ? DW'($urandom) : DW'(base + i));
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: drive ready, sample pre-edge, advance, then update the FIFO model.
  task automatic step();
    logic rd, xf;
    logic [DW-1:0] d, e;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    rd = fifo_rd_en;
    xf = out_valid & out_ready;
    d  = out_data;
    if (hold_v && !uf_prev) chk("hold", 32'({out_valid, out_data}), 32'({1'b1, held}));
    if (rd) chk("rd_nonempty", 32'(fifo_empty), 0);
    if (xf) begin
      if (exp_q.size() == 0) chk("xfer_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("data", 32'(d), 32'(e));
      end
      deliv++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    if (rd) rd_cycles.push_back(cyc);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    hold_v  = out_valid & ~out_ready;
    held    = d;
    uf_prev = fifo_underflow;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      reads++;
      if (fq.size() > 0) fifo_rd_data = fq.pop_front();
      exp_q.push_back(fifo_rd_data);
    end
    while (wr_at.size() > 0 && wr_at[0] <= cyc) begin
      void'(wr_at.pop_front());
      fq.push_back(wr_b.pop_front());
    end
    fifo_empty = (fq.size() == 0);
    chk("credit", 32'((reads - deliv) <= 2), 1);
  endtask

  task automatic run_burst(input int len, input int mode, input int poke_at, input int budget);
    int n;
    rdy_mode = mode; reads = 0; deliv = 0; done_cnt = 0;
    first_xfer = -1; last_xfer = -1; done_cyc = -1;
    rd_cycles.delete(); exp_q.delete();
    start_cyc = cyc;
    start = 1'b1; burst_len = LW'(len);
    step();
    start = 1'b0;
    chk("err_clr", 32'(err_underflow), 0);
    chk("busy_go", 32'(busy), 32'(len != 0));
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (n == poke_at) begin start = 1'b1; burst_len = LW'(1); end
      step();
      start = 1'b0;
      n++;
    end
    chk("done_seen", done_cnt, 1);
    step();
    chk("done_once", done_cnt, 1);
    chk("busy_end", 32'(busy), 0);
    chk("reads", reads, len);
    chk("deliv", deliv, len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; hold_v = 1'b0; uf_prev = 1'b0; rdy_mode = 0;
    // Outputs stay quiet under reset regardless of input noise.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); burst_len = LW'($urandom); fifo_empty = 1'($urandom);
      fifo_underflow = 1'($urandom); out_ready = 1'($urandom); fifo_rd_data = DW'($urandom);
      @(posedge clk); #1;
      chk("rst_outs", 32'({fifo_rd_en, out_valid, busy, done, err_underflow, out_data}), 0);
    end
    start = 1'b0; fifo_underflow = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0; burst_len = '0;
    reset = 1'b1;
    step();
    chk("idle_after_rst", 32'({busy, done, fifo_rd_en, out_valid}), 0);

    // Streaming: reads back-to-back, first byte two edges after the accepting edge.
    load(4, 'h10);
    run_burst(4, 0, -1, 50);
    chk("rd_count", rd_cycles.size(), 4);
    if (rd_cycles.size() == 4) begin
      chk("rd_first", rd_cycles[0], start_cyc + 1);
      chk("rd_last", rd_cycles[3], start_cyc + 4);
    end
    chk("first_xfer", first_xfer, start_cyc + 3);
    chk("last_xfer", last_xfer, start_cyc + 6);

    // Backpressure with ready pattern 1,0,0.
    load(6, -1);
    run_burst(6, 1, -1, 200);

    // Empty stall: one byte now, then +10 and +15 cycles.
    load(1, -1);
    wr_at.push_back(cyc + 10); wr_b.push_back(8'hA5);
    wr_at.push_back(cyc + 15); wr_b.push_back(8'h5A);
    run_burst(3, 0, -1, 100);
    chk("stall_err", 32'(err_underflow), 0);
    chk("stall_late", 32'(done_cyc > start_cyc + 15), 1);

    // Null burst.
    run_burst(0, 0, -1, 10);
    chk("null_done_at", done_cyc, start_cyc + 1);
    chk("null_rd", rd_cycles.size(), 0);

    // Maximum length from a full FIFO.
    load(32, -1);
    run_burst(31, 2, -1, 400);
    chk("max_left", fq.size(), 1);
    fq.delete(); fifo_empty = 1'b1;

    // Start while busy must not reprogram the length.
    load(5, -1);
    run_burst(5, 1, 2, 200);

    // Underflow abort with the buffer full.
    load(8, -1);
    rdy_mode = 3; reads = 0; deliv = 0; exp_q.delete();
    start = 1'b1; burst_len = LW'(8);
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_abort_valid", 32'(out_valid), 1);
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    chk("abort_done", 32'(done), 1);
    chk("abort_err", 32'(err_underflow), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_flush", 32'(out_valid), 0);
    step();
    chk("abort_idle", 32'({done, busy}), 0);
    chk("err_sticky", 32'(err_underflow), 1);
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1; hold_v = 1'b0;

    // Next start clears the sticky error.
    load(2, -1);
    run_burst(2, 0, -1, 50);

    // Underflow while idle is ignored.
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    chk("idle_uf", 32'({err_underflow, done, busy}), 0);

    // Reset mid-burst.
    load(6, -1);
    rdy_mode = 0; reads = 0; deliv = 0; exp_q.delete();
    start = 1'b1; burst_len = LW'(6);
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("mid_rst", 32'({fifo_rd_en, out_valid, busy, done, err_underflow, out_data}), 0);
    @(posedge clk); #1;
    reset = 1'b1; hold_v = 1'b0;
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 0);

    // Random bursts with trickling FIFO fill and random backpressure.
    for (int t = 0; t < 6; t++) begin
      int blen, pre, at;
      blen = $urandom_range(1, 20);
      pre  = $urandom_range(0, blen);
      load(pre, -1);
      at = cyc;
      for (int k = pre; k < blen; k++) begin
        at += $urandom_range(1, 4);
        wr_at.push_back(at);
        wr_b.push_back(DW'($urandom));
      end
      run_burst(blen, 2, -1, 400);
      chk("rand_err", 32'(err_underflow), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
